// File: rtl/hyper_pipeline_elastic_pkg.sv
// Shared types and helpers for the elastic (skid-buffered) register pipeline.
// Imported by the slice and the top level.
package hyper_pipeline_elastic_pkg;

    // Handshake events seen by the occupancy counter in one cycle.
    typedef struct packed {
        logic push;
        logic pop;
    } occ_evt_t;

    // Occupancy spans 0..2*stages; keep at least one bit for the bypass build.
    function automatic int unsigned occ_width(input int unsigned stages);
        return (stages == 0) ? 1 : $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/hyper_pipeline_elastic_slice.sv
// One two-entry skid buffer: main register drives the output, skid absorbs one
// beat while downstream stalls, so input ready comes straight from a flop.
module hyper_pipeline_elastic_slice #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          RESET_DATA = 1'b0
) (
    input  logic             ap_clk,
    input  logic             areset,
    input  logic             flush,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_m_q, valid_m_d;
    logic             valid_s_q, valid_s_d;
    logic [WIDTH-1:0] data_m_q, data_m_d;
    logic [WIDTH-1:0] data_s_q, data_s_d;
    logic             in_acc, out_acc;

    assign in_ready_o  = !valid_s_q;
    assign in_acc      = in_valid_i && !valid_s_q;
    assign out_acc     = valid_m_q && out_ready_i;
    assign out_valid_o = valid_m_q;
    assign out_data_o  = data_m_q;

    always_comb begin
        valid_m_d = valid_m_q;
        valid_s_d = valid_s_q;
        data_m_d  = data_m_q;
        data_s_d  = data_s_q;
        if (out_acc) begin
            valid_m_d = valid_s_q;
            data_m_d  = data_s_q;
            valid_s_d = 1'b0;
        end
        // in_acc implies the skid is empty, so it never collides with the refill above.
        if (in_acc) begin
            if (!valid_m_q || out_acc) begin
                valid_m_d = 1'b1;
                data_m_d  = in_data_i;
            end else begin
                valid_s_d = 1'b1;
                data_s_d  = in_data_i;
            end
        end
        if (flush) begin
            valid_m_d = 1'b0;
            valid_s_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            valid_m_q <= 1'b0;
            valid_s_q <= 1'b0;
        end else begin
            valid_m_q <= valid_m_d;
            valid_s_q <= valid_s_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (RESET_DATA && areset) begin
            data_m_q <= '0;
            data_s_q <= '0;
        end else begin
            data_m_q <= data_m_d;
            data_s_q <= data_s_d;
        end
    end

endmodule

// File: rtl/hyper_pipeline_elastic.sv
// Chain of STAGES skid-buffer slices with flush and an occupancy counter;
// STAGES=0 degenerates to a combinational pass-through.
module hyper_pipeline_elastic
    import hyper_pipeline_elastic_pkg::*;
#(
    parameter int unsigned  STAGES     = 2,
    parameter int unsigned  WIDTH      = 32,
    parameter bit           RESET_DATA = 1'b0,
    localparam int unsigned CNT_W      = occ_width(STAGES)
) (
    input  logic             ap_clk,
    input  logic             areset,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] occupancy,
    output logic             empty
);

    if (STAGES == 0) begin : g_bypass
        assign m_valid   = s_valid;
        assign m_data    = s_data;
        assign s_ready   = m_ready && !areset;
        assign occupancy = '0;
        assign empty     = 1'b1;
    end else begin : g_pipe
        logic [STAGES:0]  chain_valid;
        logic [STAGES:0]  chain_ready;
        logic [WIDTH-1:0] chain_data [STAGES+1];
        occ_evt_t         evt;
        logic [CNT_W-1:0] occ_q, occ_d;

        assign s_ready             = chain_ready[0] && !flush && !areset;
        assign chain_valid[0]      = s_valid && s_ready;
        assign chain_data[0]       = s_data;
        assign chain_ready[STAGES] = m_ready;

        for (genvar k = 0; k < STAGES; k++) begin : g_slice
            hyper_pipeline_elastic_slice #(
                .WIDTH      (WIDTH),
                .RESET_DATA (RESET_DATA)
            ) u_slice (
                .ap_clk      (ap_clk),
                .areset      (areset),
                .flush       (flush),
                .in_valid_i  (chain_valid[k]),
                .in_ready_o  (chain_ready[k]),
                .in_data_i   (chain_data[k]),
                .out_valid_o (chain_valid[k+1]),
                .out_ready_i (chain_ready[k+1]),
                .out_data_o  (chain_data[k+1])
            );
        end

        // The last slice clears one edge into reset; mask it so reset looks immediate.
        assign m_valid = chain_valid[STAGES] && !areset;
        assign m_data  = (RESET_DATA && areset) ? '0 : chain_data[STAGES];

        always_comb begin
            evt.push = s_valid && s_ready;
            evt.pop  = m_valid && m_ready;
            occ_d    = occ_q;
            if (flush) begin
                occ_d = '0;
            end else if (evt.push && !evt.pop) begin
                occ_d = occ_q + CNT_W'(1);
            end else if (!evt.push && evt.pop) begin
                occ_d = occ_q - CNT_W'(1);
            end
        end

        always_ff @(posedge ap_clk) begin
            if (areset) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end

        assign occupancy = occ_q;
        assign empty     = (occ_q == '0);

        a_occ_bound: assert property (@(posedge ap_clk) disable iff (areset)
            32'(occ_q) <= 32'(2 * STAGES));
    end

endmodule

// File: tb/tb_hyper_pipeline_elastic.sv
// Bench for hyper_pipeline_elastic: a 4-stage RESET_DATA build checked against a
// queue model, plus a 0-stage pass-through build sharing the same inputs.
module tb_hyper_pipeline_elastic;

    localparam int unsigned ST = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    logic          ap_clk = 1'b0;
    logic          areset = 1'b1;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          s_ready, m_valid, empty;
    logic [W-1:0]  m_data;
    logic [CW-1:0] occupancy;
    logic          s_ready0, m_valid0, empty0;
    logic [W-1:0]  m_data0;
    logic [0:0]    occ0;

    always #5 ap_clk = ~ap_clk;

    hyper_pipeline_elastic #(.STAGES(ST), .WIDTH(W), .RESET_DATA(1'b1)) u_dut (
        .ap_clk    (ap_clk),
        .areset    (areset),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occupancy (occupancy),
        .empty     (empty)
    );

    hyper_pipeline_elastic #(.STAGES(0), .WIDTH(W), .RESET_DATA(1'b0)) u_dut0 (
        .ap_clk    (ap_clk),
        .areset    (areset),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready0),
        .s_data    (s_data),
        .m_valid   (m_valid0),
        .m_ready   (m_ready),
        .m_data    (m_data0),
        .occupancy (occ0),
        .empty     (empty0)
    );

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] model_q[$];
    int           cyc = 0;
    int           pops = 0;
    int           pushes = 0;
    int           max_occ = 0;
    int           first_pop_cyc = -1;
    int           last_pop_cyc = -1;
    logic [W-1:0] last_pop_data = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: samples mid-low phase, before the driver logs this cycle's push.
    always @(negedge ap_clk) begin
        logic [W-1:0] exp_d;
        #2;
        cyc++;
        check("bypass_valid", 32'(m_valid0), 32'(s_valid));
        check("bypass_data", 32'(m_data0), 32'(s_data));
        check("bypass_ready", 32'(s_ready0), 32'(m_ready && !areset));
        check("bypass_empty", 32'({empty0, occ0}), 32'h2);
        if (areset) begin
            check("rst_m_valid", 32'(m_valid), 0);
            check("rst_m_data", 32'(m_data), 0);
            check("rst_s_ready", 32'(s_ready), 0);
            model_q.delete();
        end else begin
            check("occupancy", 32'(occupancy), 32'(model_q.size()));
            check("empty", 32'(empty), 32'(model_q.size() == 0));
            if (model_q.size() == 2 * ST) check("full_s_ready", 32'(s_ready), 0);
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            if (m_valid && m_ready) begin
                if (model_q.size() == 0) begin
                    check("unexpected_beat", 32'(m_valid), 0);
                end else begin
                    exp_d = model_q.pop_front();
                    check("m_data", 32'(m_data), 32'(exp_d));
                end
                pops++;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc  = cyc;
                last_pop_data = m_data;
            end
            if (flush) model_q.delete();
        end
    end

    // Driver: one cycle of stimulus; accepted beats become expected outputs.
    task automatic step(input logic sv, input logic [W-1:0] sd, input logic mr,
                        input logic fl, input logic rs, output logic acc);
        @(negedge ap_clk);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        areset  = rs;
        #3;
        acc = sv && s_ready;
        if (acc) begin
            model_q.push_back(sd);
            pushes++;
        end
    endtask

    initial begin
        logic acc;
        int   start_cyc, n, base, guard, target;

        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        check("post_rst_s_ready", 32'(s_ready), 1);
        check("post_rst_m_valid", 32'(m_valid), 0);
        check("post_rst_occ", 32'(occupancy), 0);
        check("post_rst_empty", 32'(empty), 1);

        // Back-to-back burst with no backpressure: latency ST, one beat per cycle.
        first_pop_cyc = -1;
        max_occ = 0;
        base = pops;
        start_cyc = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, W'(i), 1'b1, 1'b0, 1'b0, acc);
            if (i == 1) start_cyc = cyc;
            check("burst_accept", 32'(acc), 1);
        end
        guard = 0;
        while (pops - base < 8 && guard < 30) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
            guard++;
        end
        check("burst_pops", 32'(pops - base), 8);
        check("burst_latency", 32'(first_pop_cyc - start_cyc), ST);
        check("burst_span", 32'(last_pop_cyc - first_pop_cyc), 7);
        check("burst_peak_occ", 32'(max_occ), ST);

        // Stalled downstream: capacity is 2*ST, then drain in order.
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, W'(16'h100 + n), 1'b0, 1'b0, 1'b0, acc);
            if (acc) n++;
        end
        check("fill_accepts", 32'(n), 2 * ST);
        check("fill_s_ready", 32'(s_ready), 0);
        check("fill_occ", 32'(occupancy), 2 * ST);
        guard = 0;
        do begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
            guard++;
        end while (!s_ready && guard < 2 * ST + 2);
        check("drain_s_ready", 32'(s_ready), 1);
        guard = 0;
        while (model_q.size() != 0 && guard < 40) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
            guard++;
        end
        check("drain_complete", 32'(model_q.size()), 0);

        // Random traffic with occasional flushes.
        target = pushes + 4000;
        guard = 0;
        while (pushes < target && guard < 40000) begin
            step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 63) == 0), 1'b0, acc);
            guard++;
        end
        check("rand_progress", 32'(pushes >= target), 1);
        guard = 0;
        while (model_q.size() != 0 && guard < 60) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
            guard++;
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        check("rand_drained_occ", 32'(occupancy), 0);

        // Flush with three beats held; the flush-cycle beat must be refused.
        for (int i = 0; i < 3; i++) step(1'b1, W'(16'h30 + i), 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0, acc);
        check("flush_s_ready", 32'(s_ready), 0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
        check("flush_m_valid", 32'(m_valid), 0);
        check("flush_occ", 32'(occupancy), 0);
        check("flush_empty", 32'(empty), 1);
        base = pops;
        step(1'b1, 16'h0077, 1'b1, 1'b0, 1'b0, acc);
        check("flush_next_accept", 32'(acc), 1);
        guard = 0;
        while (guard < 12) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
            guard++;
        end
        check("flush_next_pops", 32'(pops - base), 1);
        check("flush_next_data", 32'(last_pop_data), 32'h77);

        // Reset mid-stream with four beats in flight.
        for (int i = 0; i < 4; i++) step(1'b1, W'(16'h50 + i), 1'b0, 1'b0, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
        check("pre_rst_occ", 32'(occupancy), 4);
        step(1'b1, 16'h0055, 1'b1, 1'b0, 1'b1, acc);
        step(1'b1, 16'h0055, 1'b1, 1'b1, 1'b1, acc);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        check("rel_s_ready", 32'(s_ready), 1);
        check("rel_occ", 32'(occupancy), 0);
        base = pops;
        step(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0, acc);
        check("rel_accept", 32'(acc), 1);
        guard = 0;
        while (guard < 12) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
            guard++;
        end
        check("rel_pops", 32'(pops - base), 1);
        check("rel_data", 32'(last_pop_data), 32'hAA);
        check("final_model_empty", 32'(model_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
